// File: rtl/read_empty.sv
// ---------------------------------------------------------------------------
// read_empty
// Read-side pointer and empty logic for the asynchronous FIFO. This is the
// counterpart of the write-side full logic. It brings the write gray pointer
// into the read clock domain and keeps the read binary and gray pointers. It
// also produces registered empty, almost_empty, occupancy and underflow
// flags, drives the RAM read address, and exports the read gray pointer
// towards the write-domain synchroniser.
// ---------------------------------------------------------------------------
module read_empty #(
   parameter int FIFO_addr_size  = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int ALMOST_EMPTY_TH = 1
) (
   input  logic                      clk_r,
   input  logic                      rst_r,
   input  logic                      r_en,
   input  logic [FIFO_addr_size:0]   w_pointer_gray,
   output logic                      empty,
   output logic                      almost_empty,
   output logic                      underflow,
   output logic [FIFO_addr_size-1:0] r_addr,
   output logic [FIFO_addr_size:0]   r_pointer_gray,
   output logic [FIFO_addr_size:0]   r_level
);

   // Pointers carry one extra wrap bit above the RAM address, so an empty
   // FIFO and a full FIFO can be told apart.
   localparam int PW = FIFO_addr_size + 1;

   // The threshold is compared against a modulo level, so it is held at the
   // pointer width.
   localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

   logic [PW-1:0] r_bin;
   logic [PW-1:0] r_syncChain [SYNC_STAGES];

   logic          w_rdOk;
   logic [PW-1:0] w_binNext;
   logic [PW-1:0] w_grayNext;
   logic [PW-1:0] w_graySync;
   logic [PW-1:0] w_binSync;
   logic [PW-1:0] w_levelNext;

   // Plain flop chain carrying the write gray pointer into clk_r. Only one
   // bit of a gray code changes per step, so every sampled value is either
   // the old pointer or the new one. No logic sits between the stages.
   always_ff @(posedge clk_r or posedge rst_r) begin
      if (rst_r) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_syncChain[i] <= '0;
         end
      end else begin
         r_syncChain[0] <= w_pointer_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_syncChain[i] <= r_syncChain[i-1];
         end
      end
   end

   assign w_graySync = r_syncChain[SYNC_STAGES-1];

   // Gray to binary conversion of the synchronised write pointer. Each
   // binary bit is the XOR of all gray bits at and above its position. This
   // leaves the MSB copied and gives b[i] = b[i+1] ^ g[i].
   always_comb begin
      w_binSync = '0;
      for (int i = 0; i < PW; i++) begin
         w_binSync[i] = ^(w_graySync >> i);
      end
   end

   // Next-state read pointer. A read is accepted only while the FIFO is not
   // empty, so a read request on an empty FIFO leaves both pointers and the
   // RAM address untouched.
   always_comb begin
      w_rdOk      = r_en & ~empty;
      w_binNext   = r_bin + PW'(w_rdOk);
      w_grayNext  = (w_binNext >> 1) ^ w_binNext;
      w_levelNext = w_binSync - w_binNext;
   end

   // All flags are registered from next-state values. The read that takes
   // the last word therefore raises empty and drops the level on the same
   // edge. The level arithmetic is modulo the pointer width, so wrapping
   // through zero needs no special handling. Because the write pointer
   // arrives late, empty can only deassert late, never early.
   always_ff @(posedge clk_r or posedge rst_r) begin
      if (rst_r) begin
         r_bin          <= '0;
         r_pointer_gray <= '0;
         empty          <= 1'b1;
         almost_empty   <= 1'b1;
         underflow      <= 1'b0;
         r_level        <= '0;
      end else begin
         r_bin          <= w_binNext;
         r_pointer_gray <= w_grayNext;
         empty          <= (w_grayNext == w_graySync);
         almost_empty   <= (w_levelNext <= AE_TH);
         underflow      <= r_en & empty;
         r_level        <= w_levelNext;
      end
   end

   // The RAM is addressed by the low bits of the binary pointer. The head
   // word is therefore presented for the read accepted in this cycle.
   assign r_addr = r_bin[FIFO_addr_size-1:0];

endmodule

// File: tb/tb_read_empty.sv
// ---------------------------------------------------------------------------
// tb_read_empty
// Directed bench for read_empty at FIFO_addr_size=2, SYNC_STAGES=2,
// ALMOST_EMPTY_TH=1. Inputs change on the falling edge and outputs are
// sampled on the falling edge, half a period away from the active rising
// edge.
// ---------------------------------------------------------------------------
module tb_read_empty;

   logic       clk_r;
   logic       rst_r;
   logic       r_en;
   logic [2:0] w_pointer_gray;
   logic       empty;
   logic       almost_empty;
   logic       underflow;
   logic [1:0] r_addr;
   logic [2:0] r_pointer_gray;
   logic [2:0] r_level;

   int         testsRun;
   int         testsFailed;
   logic [2:0] grayTab [8];
   logic [2:0] wIdx;
   logic [2:0] rIdx;

   read_empty #(
      .FIFO_addr_size  (2),
      .SYNC_STAGES     (2),
      .ALMOST_EMPTY_TH (1)
   ) dut (
      .clk_r          (clk_r),
      .rst_r          (rst_r),
      .r_en           (r_en),
      .w_pointer_gray (w_pointer_gray),
      .empty          (empty),
      .almost_empty   (almost_empty),
      .underflow      (underflow),
      .r_addr         (r_addr),
      .r_pointer_gray (r_pointer_gray),
      .r_level        (r_level)
   );

   // Free-running read clock with a 10-unit period.
   initial begin
      clk_r = 1'b0;
      forever #5 clk_r = ~clk_r;
   end

   // Drive one cycle of inputs, then wait for the falling edge after the
   // rising edge that consumes them.
   task automatic applyStimulus(input logic ren, input logic [2:0] wpg);
      r_en           = ren;
      w_pointer_gray = wpg;
      @(negedge clk_r);
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check every output against its reset value.
   task automatic checkResetState(input string tag);
      checkOutput({tag, " empty"},        32'(empty),          32'd1);
      checkOutput({tag, " almost_empty"}, 32'(almost_empty),   32'd1);
      checkOutput({tag, " underflow"},    32'(underflow),      32'd0);
      checkOutput({tag, " r_addr"},       32'(r_addr),         32'd0);
      checkOutput({tag, " r_ptr_gray"},   32'(r_pointer_gray), 32'd0);
      checkOutput({tag, " r_level"},      32'(r_level),        32'd0);
   endtask

   // Directed sequence covering reset, fill, drain, underflow, wrap and an
   // asynchronous mid-cycle reset.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      grayTab[0] = 3'b000; grayTab[1] = 3'b001; grayTab[2] = 3'b011; grayTab[3] = 3'b010;
      grayTab[4] = 3'b110; grayTab[5] = 3'b111; grayTab[6] = 3'b101; grayTab[7] = 3'b100;

      rst_r          = 1'b1;
      r_en           = 1'b1;
      w_pointer_gray = 3'b000;
      @(negedge clk_r);
      @(negedge clk_r);
      checkResetState("reset");
      r_en = 1'b0;
      rst_r = 1'b0;
      applyStimulus(1'b0, 3'b000);
      checkOutput("idle empty", 32'(empty),   32'd1);
      checkOutput("idle level", 32'(r_level), 32'd0);

      applyStimulus(1'b0, 3'b001);
      applyStimulus(1'b0, 3'b011);
      checkOutput("fill1 empty", 32'(empty),   32'd1);
      checkOutput("fill1 level", 32'(r_level), 32'd0);
      applyStimulus(1'b0, 3'b011);
      checkOutput("fill2 empty", 32'(empty),        32'd0);
      checkOutput("fill2 level", 32'(r_level),      32'd1);
      checkOutput("fill2 ae",    32'(almost_empty), 32'd1);
      applyStimulus(1'b0, 3'b011);
      checkOutput("fill3 empty", 32'(empty),        32'd0);
      checkOutput("fill3 level", 32'(r_level),      32'd2);
      checkOutput("fill3 ae",    32'(almost_empty), 32'd0);

      applyStimulus(1'b1, 3'b011);
      checkOutput("drain1 r_addr", 32'(r_addr),         32'd1);
      checkOutput("drain1 rgray",  32'(r_pointer_gray), 32'b001);
      checkOutput("drain1 level",  32'(r_level),        32'd1);
      checkOutput("drain1 ae",     32'(almost_empty),   32'd1);
      checkOutput("drain1 empty",  32'(empty),          32'd0);
      applyStimulus(1'b1, 3'b011);
      checkOutput("drain2 r_addr", 32'(r_addr),         32'd2);
      checkOutput("drain2 rgray",  32'(r_pointer_gray), 32'b011);
      checkOutput("drain2 level",  32'(r_level),        32'd0);
      checkOutput("drain2 empty",  32'(empty),          32'd1);
      checkOutput("drain2 uflow",  32'(underflow),      32'd0);

      applyStimulus(1'b1, 3'b011);
      checkOutput("uflow1 pulse",  32'(underflow),      32'd1);
      checkOutput("uflow1 r_addr", 32'(r_addr),         32'd2);
      checkOutput("uflow1 rgray",  32'(r_pointer_gray), 32'b011);
      checkOutput("uflow1 empty",  32'(empty),          32'd1);
      applyStimulus(1'b0, 3'b011);
      checkOutput("uflow1 clear",  32'(underflow),      32'd0);
      applyStimulus(1'b1, 3'b011);
      checkOutput("uflow2 first",  32'(underflow),      32'd1);
      applyStimulus(1'b1, 3'b011);
      checkOutput("uflow2 second", 32'(underflow),      32'd1);
      checkOutput("uflow2 r_addr", 32'(r_addr),         32'd2);
      applyStimulus(1'b0, 3'b011);
      checkOutput("uflow2 clear",  32'(underflow),      32'd0);

      rst_r = 1'b1;
      w_pointer_gray = 3'b000;
      @(negedge clk_r);
      rst_r = 1'b0;
      applyStimulus(1'b0, 3'b110);
      applyStimulus(1'b0, 3'b110);
      checkOutput("full2 level", 32'(r_level), 32'd0);
      applyStimulus(1'b0, 3'b110);
      checkOutput("full level", 32'(r_level),      32'd4);
      checkOutput("full empty", 32'(empty),        32'd0);
      checkOutput("full ae",    32'(almost_empty), 32'd0);

      for (int k = 1; k <= 12; k++) begin
         wIdx = 3'(4 + k);
         rIdx = 3'(k);
         applyStimulus(1'b1, grayTab[wIdx]);
         checkOutput($sformatf("wrap%0d level", k), 32'(r_level),        (k == 1) ? 32'd3 : 32'd2);
         checkOutput($sformatf("wrap%0d empty", k), 32'(empty),          32'd0);
         checkOutput($sformatf("wrap%0d ae", k),    32'(almost_empty),   32'd0);
         checkOutput($sformatf("wrap%0d rgray", k), 32'(r_pointer_gray), 32'(grayTab[rIdx]));
         checkOutput($sformatf("wrap%0d raddr", k), 32'(r_addr),         32'(rIdx[1:0]));
      end
      r_en = 1'b0;

      rst_r = 1'b1;
      w_pointer_gray = 3'b000;
      @(negedge clk_r);
      rst_r = 1'b0;
      applyStimulus(1'b0, 3'b010);
      applyStimulus(1'b0, 3'b010);
      applyStimulus(1'b0, 3'b010);
      checkOutput("pre-rst level", 32'(r_level), 32'd3);
      checkOutput("pre-rst empty", 32'(empty),   32'd0);
      @(posedge clk_r);
      #3;
      rst_r = 1'b1;
      #1;
      checkResetState("async rst");
      w_pointer_gray = 3'b000;
      @(negedge clk_r);
      rst_r = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b0, 3'b000);
         checkOutput($sformatf("post-rst%0d empty", k), 32'(empty),   32'd1);
         checkOutput($sformatf("post-rst%0d level", k), 32'(r_level), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
